// File: rtl/pe_conv_controller.sv
// ============================================================================
// Module   : pe_conv_controller
// Purpose  : Sequencer for the 3x3 PE-with-output-buffer datapath. Runs one
//            convolution layer pass: for each input channel it loads the
//            kernel and walks every output pixel. Channel 0 writes bias plus
//            product. Later channels read-modify-write the accumulator through
//            port A. After the last channel the finished map is streamed out
//            through port B.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            start, num_in_ch, busy,
//            done                       - layer scheduler handshake
//            kernel_valid/ready,
//            Wr_kernel, Rst_kernel      - kernel load control
//            win_valid/ready            - line-buffer window handshake
//            add_bias, ena/wea/addra    - PE datapath / BRAM port A
//            enb/addrb, out_ready,
//            out_valid, out_last        - BRAM port B output stream
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_conv_controller #(
  parameter int IMG_DIM    = 128,
  parameter int ADDR_WIDTH = 14,
  parameter int CH_WIDTH   = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CH_WIDTH-1:0]   num_in_ch,
  output logic                  busy,
  output logic                  done,
  input  logic                  kernel_valid,
  output logic                  kernel_ready,
  input  logic                  win_valid,
  output logic                  win_ready,
  output logic                  Wr_kernel,
  output logic                  Rst_kernel,
  output logic                  add_bias,
  output logic                  ena_output_BRAM,
  output logic                  wea_output_BRAM,
  output logic [ADDR_WIDTH-1:0] addra_output_BRAM,
  output logic                  enb_output_BRAM,
  output logic [ADDR_WIDTH-1:0] addrb_output_BRAM,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic                  out_last
);

  localparam int unsigned           PIX_COUNT = IMG_DIM * IMG_DIM;
  localparam logic [ADDR_WIDTH-1:0] PIX_LAST  = ADDR_WIDTH'(PIX_COUNT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_LOAD_K = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_WR     = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;
  localparam logic [2:0] S_FIN    = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pix_q, pix_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [CH_WIDTH-1:0]   ch_q, ch_d;
  logic [CH_WIDTH-1:0]   num_ch_q, num_ch_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  done_q, done_d;
  logic                  advance;

  wire w_first_ch = (ch_q == '0);
  wire w_last_ch  = (ch_q == (num_ch_q - CH_WIDTH'(1)));

  // --------------------------------------------------------------------------
  // State and counter registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pix_q       <= '0;
      rd_q        <= '0;
      ch_q        <= '0;
      num_ch_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      rd_q        <= rd_d;
      ch_q        <= ch_d;
      num_ch_q    <= num_ch_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and counter logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    rd_d        = rd_q;
    ch_d        = ch_q;
    num_ch_d    = num_ch_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    // done is registered from FIN so it lands after the final out_valid,
    // in the same cycle busy drops.
    done_d      = (state_q == S_FIN);
    advance     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_ch_d = num_in_ch;
          state_d  = (num_in_ch == '0) ? S_FIN : S_CLR;
        end
      end
      S_CLR: begin
        ch_d    = '0;
        pix_d   = '0;
        state_d = S_LOAD_K;
      end
      S_LOAD_K: begin
        if (kernel_valid) state_d = S_WAIT;
      end
      S_WAIT: begin
        // Channel 0 writes in the arrival cycle. Later channels use the
        // arrival cycle as the accumulator read, so each pixel costs two
        // cycles: read here, write in S_WR.
        if (win_valid) begin
          if (w_first_ch) advance = 1'b1;
          else            state_d = S_WR;
        end
      end
      S_WR: begin
        advance = 1'b1;
      end
      S_DRAIN: begin
        if (out_ready) begin
          out_valid_d = 1'b1;
          rd_d        = rd_q + ADDR_WIDTH'(1);
          if (rd_q == PIX_LAST) begin
            out_last_d = 1'b1;
            rd_d       = '0;
            state_d    = S_FIN;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (advance) begin
      if (pix_q != PIX_LAST) begin
        pix_d   = pix_q + ADDR_WIDTH'(1);
        state_d = S_WAIT;
      end else if (!w_last_ch) begin
        pix_d   = '0;
        ch_d    = ch_q + CH_WIDTH'(1);
        state_d = S_LOAD_K;
      end else begin
        pix_d   = '0;
        rd_d    = '0;
        state_d = S_DRAIN;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    busy              = (state_q != S_IDLE);
    done              = done_q;
    kernel_ready      = 1'b0;
    win_ready         = 1'b0;
    Wr_kernel         = 1'b0;
    Rst_kernel        = 1'b1;
    add_bias          = 1'b0;
    ena_output_BRAM   = 1'b0;
    wea_output_BRAM   = 1'b0;
    addra_output_BRAM = pix_q;
    enb_output_BRAM   = 1'b0;
    addrb_output_BRAM = rd_q;
    out_valid         = out_valid_q;
    out_last          = out_last_q;

    case (state_q)
      S_CLR: begin
        Rst_kernel = 1'b0;
      end
      S_LOAD_K: begin
        kernel_ready = 1'b1;
        Wr_kernel    = kernel_valid;
      end
      S_WAIT: begin
        if (win_valid) begin
          ena_output_BRAM = 1'b1;
          if (w_first_ch) begin
            wea_output_BRAM = 1'b1;
            add_bias        = 1'b1;
            win_ready       = 1'b1;
          end
        end
      end
      S_WR: begin
        ena_output_BRAM = 1'b1;
        wea_output_BRAM = 1'b1;
        win_ready       = 1'b1;
      end
      S_DRAIN: begin
        enb_output_BRAM = out_ready;
      end
      default: begin
      end
    endcase
  end

endmodule

`default_nettype wire
